instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 24 ++
 rtl/instr_fetch.sv | 153 +++++++++++++++
 tb/tb_instr_fetch.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-to-memory-controller bus: request/address out, sticky done flag and data back.
interface instr_fetch_if;
    logic        if_read_or_not;
    logic [31:0] intru_addr;
    logic        if_load_done;
    logic [31:0] mem_ctrl_instru_to_if;
    logic [1:0]  mem_ctrl_busy_state;

    modport master (
        output if_read_or_not,
        output intru_addr,
        input  if_load_done,
        input  mem_ctrl_instru_to_if,
        input  mem_ctrl_busy_state
    );

    modport slave (
        input  if_read_or_not,
        input  intru_addr,
        output if_load_done,
        output mem_ctrl_instru_to_if,
        output mem_ctrl_busy_state
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch with a direct-mapped one-word-line icache.
// state  | meaning
// LOOKUP | probe cache at pc, present hits, start a fill on a miss
// MISS   | fill outstanding; intru_addr held until memctrl reports done
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          IDX_BITS = 6
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    instr_fetch_if.master        mem,
    output logic                 instr_valid,
    output logic [31:0]          instr,
    output logic [31:0]          instr_pc,
    input  logic                 decode_stall,
    input  logic                 jump_en,
    input  logic [31:0]          jump_pc
);
    localparam int LINES    = 1 << IDX_BITS;
    localparam int TAG_BITS = 30 - IDX_BITS;

    typedef enum logic {LOOKUP, MISS} state_t;

    state_t              state_q, state_d;
    logic [31:0]         pc_q, pc_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         instr_q, instr_d;
    logic [31:0]         ipc_q, ipc_d;
    logic                req_q, req_d;
    logic                armed_q, armed_d;
    logic                discard_q, discard_d;
    logic                ivalid_q, ivalid_d;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_mem [LINES];
    logic [31:0]         data_mem [LINES];

    logic [IDX_BITS-1:0] pc_idx, fill_idx;
    logic [TAG_BITS-1:0] pc_tag, fill_tag;
    logic                hit, slot_free, fill_we;
    logic                unused_busy;

    assign pc_idx    = pc_q[IDX_BITS+1:2];
    assign pc_tag    = pc_q[31:IDX_BITS+2];
    assign fill_idx  = addr_q[IDX_BITS+1:2];
    assign fill_tag  = addr_q[31:IDX_BITS+2];
    assign hit       = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);
    assign slot_free = !ivalid_q || !decode_stall;

    // busy bits are informational only and never gate a request
    assign unused_busy = ^mem.mem_ctrl_busy_state;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        instr_d   = instr_q;
        ipc_d     = ipc_q;
        req_d     = req_q;
        armed_d   = armed_q;
        discard_d = discard_q;
        ivalid_d  = ivalid_q;
        fill_we   = 1'b0;
        if (rdy_in) begin
            case (state_q)
                LOOKUP: begin
                    if (jump_en) begin
                        pc_d     = jump_pc;
                        ivalid_d = 1'b0;
                    end else if (slot_free) begin
                        if (hit) begin
                            instr_d  = data_mem[pc_idx];
                            ipc_d    = pc_q;
                            ivalid_d = 1'b1;
                            pc_d     = pc_q + 32'd4;
                        end else begin
                            state_d   = MISS;
                            req_d     = 1'b1;
                            addr_d    = pc_q;
                            armed_d   = 1'b0;
                            discard_d = 1'b0;
                            ivalid_d  = 1'b0;
                        end
                    end
                end
                MISS: begin
                    if (jump_en) begin
                        pc_d      = jump_pc;
                        discard_d = 1'b1;
                        ivalid_d  = 1'b0;
                    end
                    // the done flag is sticky, so the first edge can still see the previous fill's done
                    if (!armed_q) begin
                        armed_d = 1'b1;
                    end else if (mem.if_load_done) begin
                        fill_we = 1'b1;
                        req_d   = 1'b0;
                        state_d = LOOKUP;
                        if (!jump_en && !discard_q && slot_free) begin
                            instr_d  = mem.mem_ctrl_instru_to_if;
                            ipc_d    = addr_q;
                            ivalid_d = 1'b1;
                            pc_d     = addr_q + 32'd4;
                        end else if (!jump_en && slot_free) begin
                            ivalid_d = 1'b0;
                        end
                    end
                end
                default: state_d = LOOKUP;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= LOOKUP;
            pc_q      <= RESET_PC;
            addr_q    <= 32'h0;
            instr_q   <= 32'h0;
            ipc_q     <= 32'h0;
            req_q     <= 1'b0;
            armed_q   <= 1'b0;
            discard_q <= 1'b0;
            ivalid_q  <= 1'b0;
            valid_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            instr_q   <= instr_d;
            ipc_q     <= ipc_d;
            req_q     <= req_d;
            armed_q   <= armed_d;
            discard_q <= discard_d;
            ivalid_q  <= ivalid_d;
            if (fill_we) valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (fill_we && !rst_in) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem.mem_ctrl_instru_to_if;
        end
    end

    assign mem.if_read_or_not = req_q;
    assign mem.intru_addr     = addr_q;
    assign instr_valid        = ivalid_q;
    assign instr              = instr_q;
    assign instr_pc           = ipc_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a sticky-done memctrl model of fixed latency.
module tb_instr_fetch;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b0;
    logic        decode_stall = 1'b0;
    logic        jump_en = 1'b0;
    logic [31:0] jump_pc = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    instr_fetch_if mem ();

    instr_fetch #(.RESET_PC(32'h0), .IDX_BITS(6)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .mem          (mem),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .decode_stall (decode_stall),
        .jump_en      (jump_en),
        .jump_pc      (jump_pc)
    );

    always #5 clk_in = ~clk_in;

    localparam int LAT = 5;

    int          n_vec = 0;
    int          n_err = 0;
    int          req_count = 0;
    int          addr_glitch = 0;
    int          cnt = 0;
    logic        req_prev = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic        mon_req = 1'b0;
    logic [31:0] mon_addr = 32'h0;

    function automatic logic [31:0] memfn(logic [31:0] a);
        return {a[23:0], 8'h13};
    endfunction

    initial begin
        mem.if_load_done          = 1'b0;
        mem.mem_ctrl_instru_to_if = 32'h0;
        mem.mem_ctrl_busy_state   = 2'b00;
    end

    // memctrl model: a new request clears the sticky done, the fill completes LAT edges later
    always @(posedge clk_in) begin
        req_prev <= mem.if_read_or_not;
        if (mem.if_read_or_not && !req_prev) begin
            mem.if_load_done        <= 1'b0;
            mem.mem_ctrl_busy_state <= 2'b11;
            req_addr                <= mem.intru_addr;
            cnt                     <= LAT;
            req_count               <= req_count + 1;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                mem.if_load_done          <= 1'b1;
                mem.mem_ctrl_instru_to_if <= memfn(req_addr);
                mem.mem_ctrl_busy_state   <= 2'b00;
            end
        end
    end

    always @(negedge clk_in) begin
        if (mem.if_read_or_not && mon_req && mem.intru_addr != mon_addr)
            addr_glitch = addr_glitch + 1;
        mon_req  = mem.if_read_or_not;
        mon_addr = mem.intru_addr;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic expect_instr(input string tag, input logic [31:0] epc, input logic [31:0] ein);
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_in);
            if (instr_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_seen"}, {31'b0, ok}, 32'd1);
        if (ok) begin
            chk({tag, "_pc"}, instr_pc, epc);
            chk({tag, "_instr"}, instr, ein);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req"},   {31'b0, mem.if_read_or_not}, 32'd0);
        chk({tag, "_addr"},  mem.intru_addr, 32'h0);
        chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
        chk({tag, "_instr"}, instr, 32'h0);
        chk({tag, "_ipc"},   instr_pc, 32'h0);
        chk({tag, "_pcreg"}, dut.pc_q, 32'h0);
        chk({tag, "_lines"}, {31'b0, |dut.valid_q}, 32'd0);
    endtask

    int rc;

    initial begin
        // reset with rdy low, then hold rdy low: nothing may start
        repeat (2) @(negedge clk_in);
        check_reset("rst");
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        chk("rdy_hold_req", {31'b0, mem.if_read_or_not}, 32'd0);
        chk("rdy_hold_pc", dut.pc_q, 32'h0);
        rdy_in = 1'b1;

        expect_instr("cold", 32'h0, 32'h00000013);
        chk("cold_pcreg", dut.pc_q, 32'h4);

        expect_instr("stale", 32'h4, 32'h00000413);
        chk("stale_pcreg", dut.pc_q, 32'h8);
        chk("stale_reqs", req_count, 2);

        expect_instr("fill8", 32'h8, 32'h00000813);
        rc = req_count;
        jump_en = 1'b1; jump_pc = 32'h0;
        @(negedge clk_in);
        jump_en = 1'b0;
        chk("jmp_valid", {31'b0, instr_valid}, 32'd0);
        chk("jmp_pcreg", dut.pc_q, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            chk("loop_valid", {31'b0, instr_valid}, 32'd1);
            chk("loop_pc", instr_pc, 32'(4 * k));
            chk("loop_instr", instr, memfn(32'(4 * k)));
        end
        chk("loop_noreq", req_count, rc);

        expect_instr("fill12", 32'hC, 32'h00000C13);
        jump_en = 1'b1; jump_pc = 32'h8;
        @(negedge clk_in);
        jump_en = 1'b0;
        chk("jmp8_valid", {31'b0, instr_valid}, 32'd0);
        @(negedge clk_in);
        chk("hit8_pc", instr_pc, 32'h8);
        decode_stall = 1'b1;
        repeat (4) begin
            @(negedge clk_in);
            chk("stall_valid", {31'b0, instr_valid}, 32'd1);
            chk("stall_ipc", instr_pc, 32'h8);
            chk("stall_instr", instr, 32'h00000813);
            chk("stall_pcreg", dut.pc_q, 32'hC);
        end
        decode_stall = 1'b0;
        @(negedge clk_in);
        chk("rel_valid", {31'b0, instr_valid}, 32'd1);
        chk("rel_pc", instr_pc, 32'hC);
        chk("rel_instr", instr, 32'h00000C13);

        // miss at 0x100 redirected to 0; 0x100 aliases line 0 so 0 is refetched
        jump_en = 1'b1; jump_pc = 32'h100;
        @(negedge clk_in);
        jump_en = 1'b0;
        @(negedge clk_in);
        chk("m100_req", {31'b0, mem.if_read_or_not}, 32'd1);
        chk("m100_addr", mem.intru_addr, 32'h100);
        rc = req_count;
        repeat (2) @(negedge clk_in);
        jump_en = 1'b1; jump_pc = 32'h0;
        @(negedge clk_in);
        jump_en = 1'b0;
        chk("jm_pcreg", dut.pc_q, 32'h0);
        chk("jm_req", {31'b0, mem.if_read_or_not}, 32'd1);
        chk("jm_addr", mem.intru_addr, 32'h100);
        expect_instr("jm_next", 32'h0, 32'h00000013);
        chk("jm_refetch", req_count, rc + 2);

        // reset in the middle of a fill; the late done must not land
        jump_en = 1'b1; jump_pc = 32'h100;
        @(negedge clk_in);
        jump_en = 1'b0;
        @(negedge clk_in);
        chk("m2_req", {31'b0, mem.if_read_or_not}, 32'd1);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        repeat (8) @(negedge clk_in);
        check_reset("midrst");
        rst_in = 1'b0;
        expect_instr("post_rst", 32'h0, 32'h00000013);

        chk("addr_held", addr_glitch, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
